// File: rtl/wb_regfile_writer_pkg.sv
// Shared RV32I definitions used by the write-back stage.
// Holds write-back source, load funct3 and FSM encodings.
package RV32I_definitions;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/wb_regfile_writer_load_align.sv
// Load data extraction and sign/zero extension.
// Also flags misaligned accesses and unsupported funct3 codes.
module wb_load_align
    import RV32I_definitions::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rdata,
    input  logic [1:0]   offset,
    input  logic [2:0]   funct3,
    output logic [W-1:0] data,
    output logic         illegal
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{offset, 3'b000} +: 8];
    assign h = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:  data = {{(W-8){b[7]}}, b};
            F3_LH: begin
                data    = {{(W-16){h[15]}}, h};
                illegal = offset[0];
            end
            F3_LW: begin
                data    = rdata;
                illegal = (offset != 2'd0);
            end
            F3_LBU: data = {{(W-8){1'b0}}, b};
            F3_LHU: begin
                data    = {{(W-16){1'b0}}, h};
                illegal = offset[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: sole driver of the register file write port.
// Waits for data memory on loads and stalls MEM meanwhile.
module wb_regfile_writer
    import RV32I_definitions::*;
#(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int LOAD_TIMEOUT       = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Mem_valid,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Mem_rd_addr,
    input  logic                          Mem_rd_wr_en,
    input  logic [1:0]                    Mem_wb_sel,
    input  logic [REG_DATA_WIDTH-1:0]     Mem_alu_result,
    input  logic [REG_DATA_WIDTH-1:0]     Mem_pc_plus4,
    input  logic [2:0]                    Mem_funct3,
    input  logic                          Dmem_rvalid,
    input  logic [REG_DATA_WIDTH-1:0]     Dmem_rdata,
    output logic [REGFILE_ADDR_WIDTH-1:0] Rd_addr,
    output logic [REG_DATA_WIDTH-1:0]     Rd_wr_data,
    output logic                          Rd_wr_en,
    output logic                          Wb_stall,
    output logic                          Load_err
);

    localparam int CW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    wb_state_t                   state, state_nxt;
    logic [CW-1:0]               cnt;
    logic [REGFILE_ADDR_WIDTH-1:0] ld_rd;
    logic [1:0]                  ld_off;
    logic [2:0]                  ld_f3;
    logic                        ld_we;

    logic                        accept, is_load, timeout;
    logic [1:0]                  al_off;
    logic [2:0]                  al_f3;
    logic [REG_DATA_WIDTH-1:0]   al_data;
    logic                        al_illegal;

    logic                          we_nxt, err_nxt;
    logic [REGFILE_ADDR_WIDTH-1:0] addr_nxt;
    logic [REG_DATA_WIDTH-1:0]     data_nxt;

    assign Wb_stall = (state == WB_WAIT_LOAD);
    assign accept   = Mem_valid && !Wb_stall;
    assign is_load  = (Mem_wb_sel == WB_LOAD);
    assign timeout  = (cnt == CNT_LAST);

    // One aligner: checks the incoming load in IDLE, formats data in WAIT_LOAD.
    assign al_off = Wb_stall ? ld_off : Mem_alu_result[1:0];
    assign al_f3  = Wb_stall ? ld_f3  : Mem_funct3;

    wb_load_align #(.W(REG_DATA_WIDTH)) u_align (
        .rdata   (Dmem_rdata),
        .offset  (al_off),
        .funct3  (al_f3),
        .data    (al_data),
        .illegal (al_illegal)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= WB_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WB_IDLE:
                if (accept && is_load && !al_illegal)
                    state_nxt = WB_WAIT_LOAD;
            WB_WAIT_LOAD:
                if (Dmem_rvalid || timeout)
                    state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        we_nxt   = 1'b0;
        err_nxt  = 1'b0;
        addr_nxt = Rd_addr;
        data_nxt = Rd_wr_data;
        unique case (state)
            WB_IDLE:
                if (accept) begin
                    addr_nxt = Mem_rd_addr;
                    case (Mem_wb_sel)
                        WB_ALU: begin
                            we_nxt   = Mem_rd_wr_en && (Mem_rd_addr != '0);
                            data_nxt = Mem_alu_result;
                        end
                        WB_PC4: begin
                            we_nxt   = Mem_rd_wr_en && (Mem_rd_addr != '0);
                            data_nxt = Mem_pc_plus4;
                        end
                        WB_LOAD: err_nxt = al_illegal;
                        default: ;
                    endcase
                end
            WB_WAIT_LOAD:
                if (Dmem_rvalid) begin
                    we_nxt   = ld_we && (ld_rd != '0);
                    addr_nxt = ld_rd;
                    data_nxt = al_data;
                end else begin
                    err_nxt = timeout;
                end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Rd_addr    <= '0;
            Rd_wr_data <= '0;
            Rd_wr_en   <= 1'b0;
            Load_err   <= 1'b0;
        end else begin
            Rd_wr_en <= we_nxt;
            Load_err <= err_nxt;
            if (we_nxt) begin
                Rd_addr    <= addr_nxt;
                Rd_wr_data <= data_nxt;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt    <= '0;
            ld_rd  <= '0;
            ld_off <= '0;
            ld_f3  <= '0;
            ld_we  <= 1'b0;
        end else begin
            cnt <= Wb_stall ? cnt + 1'b1 : '0;
            if (accept && is_load) begin
                ld_rd  <= Mem_rd_addr;
                ld_off <= Mem_alu_result[1:0];
                ld_f3  <= Mem_funct3;
                ld_we  <= Mem_rd_wr_en;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Scoreboard bench for wb_regfile_writer: directed plan items plus
// randomized instructions against a behavioural write-back model.
module tb_wb_regfile_writer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Mem_valid = 1'b0;
    logic [4:0]  Mem_rd_addr = '0;
    logic        Mem_rd_wr_en = 1'b0;
    logic [1:0]  Mem_wb_sel = '0;
    logic [31:0] Mem_alu_result = '0;
    logic [31:0] Mem_pc_plus4 = '0;
    logic [2:0]  Mem_funct3 = '0;
    logic        Dmem_rvalid = 1'b0;
    logic [31:0] Dmem_rdata = '0;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_wr_data;
    logic        Rd_wr_en;
    logic        Wb_stall;
    logic        Load_err;

    always #5 Clk = ~Clk;

    wb_regfile_writer dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Mem_valid      (Mem_valid),
        .Mem_rd_addr    (Mem_rd_addr),
        .Mem_rd_wr_en   (Mem_rd_wr_en),
        .Mem_wb_sel     (Mem_wb_sel),
        .Mem_alu_result (Mem_alu_result),
        .Mem_pc_plus4   (Mem_pc_plus4),
        .Mem_funct3     (Mem_funct3),
        .Dmem_rvalid    (Dmem_rvalid),
        .Dmem_rdata     (Dmem_rdata),
        .Rd_addr        (Rd_addr),
        .Rd_wr_data     (Rd_wr_data),
        .Rd_wr_en       (Rd_wr_en),
        .Wb_stall       (Wb_stall),
        .Load_err       (Load_err)
    );

    typedef struct {
        bit          err;
        logic [4:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t sbq[$];
    ev_t mon_e;
    int  vecs = 0;
    int  errs = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] w,
                                        input int off, input int f3);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            2: return w;
            4: return b;
            5: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit bad(input int off, input int f3);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (off % 2) != 0) return 1'b1;
        if (f3 == 2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge Clk) begin
        if (Reset_n && (Rd_wr_en || Load_err)) begin
            if (sbq.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_event: got we=%b err=%b addr=%0d data=%h expected none",
                         Rd_wr_en, Load_err, Rd_addr, Rd_wr_data);
            end else begin
                mon_e = sbq.pop_front();
                chk("event_err", {31'b0, Load_err}, {31'b0, mon_e.err});
                chk("event_we", {31'b0, Rd_wr_en}, {31'b0, !mon_e.err});
                if (!mon_e.err) begin
                    chk("rd_addr", {27'b0, Rd_addr}, {27'b0, mon_e.addr});
                    chk("rd_data", Rd_wr_data, mon_e.data);
                end
            end
        end
    end

    // lat: cycles from accept until rvalid is presented (>16 means never).
    task automatic issue(input logic [4:0] rd, input bit we,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [2:0] f3,
                         input logic [31:0] rdat, input int lat);
        int stalls;
        bit legal;
        ev_t e;
        Mem_valid      = 1'b1;
        Mem_rd_addr    = rd;
        Mem_rd_wr_en   = we;
        Mem_wb_sel     = sel;
        Mem_alu_result = alu;
        Mem_pc_plus4   = pc4;
        Mem_funct3     = f3;
        Dmem_rvalid    = 1'($urandom_range(0, 1));
        Dmem_rdata     = $urandom;
        legal = (sel == 2'd1) && !bad(int'(alu[1:0]), int'(f3));
        e.err  = 1'b0;
        e.addr = rd;
        e.data = (sel == 2'd2) ? pc4 : alu;
        if (sel == 2'd0 || sel == 2'd2) begin
            if (we && rd != 0) sbq.push_back(e);
        end else if (sel == 2'd1) begin
            if (!legal || lat > 16) begin
                e.err = 1'b1;
                sbq.push_back(e);
            end else if (we && rd != 0) begin
                e.data = fmt(rdat, int'(alu[1:0]), int'(f3));
                sbq.push_back(e);
            end
        end
        @(posedge Clk);
        #1;
        Mem_valid      = 1'b0;
        Dmem_rvalid    = 1'b0;
        Mem_rd_addr    = 5'($urandom);
        Mem_alu_result = $urandom;
        stalls = 0;
        while (Wb_stall && stalls < 40) begin
            stalls++;
            if (stalls == lat) begin
                Dmem_rvalid = 1'b1;
                Dmem_rdata  = rdat;
            end
            @(posedge Clk);
            #1;
            Dmem_rvalid = 1'b0;
        end
        chk("stall_cycles", stalls, legal ? ((lat <= 16) ? lat : 16) : 0);
    endtask

    initial begin
        #2;
        chk("rst_wr_en", {31'b0, Rd_wr_en}, 32'h0);
        chk("rst_addr", {27'b0, Rd_addr}, 32'h0);
        chk("rst_data", Rd_wr_data, 32'h0);
        chk("rst_err", {31'b0, Load_err}, 32'h0);
        chk("rst_stall", {31'b0, Wb_stall}, 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        issue(5'd5, 1, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 32'h0, 0);
        issue(5'd0, 1, 2'd0, 32'hFFFF_FFFF, 32'h0, 3'd0, 32'h0, 0);
        issue(5'd1, 1, 2'd2, 32'h0, 32'h104, 3'd0, 32'h0, 0);
        issue(5'd7, 1, 2'd1, 32'h1003, 32'h0, 3'd0, 32'h80FF_0011, 3);
        issue(5'd7, 1, 2'd1, 32'h1003, 32'h0, 3'd4, 32'h80FF_0011, 3);
        issue(5'd9, 1, 2'd1, 32'h1001, 32'h0, 3'd1, 32'h1111_2222, 3);
        issue(5'd9, 1, 2'd1, 32'h1000, 32'h0, 3'd3, 32'h1111_2222, 3);
        issue(5'd10, 1, 2'd1, 32'h2000, 32'h0, 3'd2, 32'hDEAD_BEEF, 99);
        Dmem_rvalid = 1'b1;
        @(posedge Clk);
        #1;
        Dmem_rvalid = 1'b0;
        issue(5'd11, 1, 2'd1, 32'h2000, 32'h0, 3'd2, 32'hCAFE_F00D, 16);
        issue(5'd12, 1, 2'd1, 32'h2002, 32'h0, 3'd1, 32'h8001_7FFF, 1);
        issue(5'd13, 1, 2'd3, 32'h5555, 32'h0, 3'd0, 32'h0, 0);

        for (int i = 0; i < 200; i++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            issue(5'($urandom), 1'($urandom), s, $urandom, $urandom,
                  3'($urandom), $urandom,
                  ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(1, 17));
            if ($urandom_range(0, 3) == 0) begin
                Dmem_rvalid = 1'($urandom);
                @(posedge Clk);
                #1;
                Dmem_rvalid = 1'b0;
            end
        end

        Mem_valid      = 1'b1;
        Mem_rd_addr    = 5'd20;
        Mem_rd_wr_en   = 1'b1;
        Mem_wb_sel     = 2'd1;
        Mem_alu_result = 32'h3000;
        Mem_funct3     = 3'd2;
        @(posedge Clk);
        #1;
        Mem_valid = 1'b0;
        @(posedge Clk);
        #1;
        chk("midload_stall", {31'b0, Wb_stall}, 32'h1);
        Reset_n = 1'b0;
        #1;
        chk("arst_stall", {31'b0, Wb_stall}, 32'h0);
        chk("arst_wr_en", {31'b0, Rd_wr_en}, 32'h0);
        chk("arst_addr", {27'b0, Rd_addr}, 32'h0);
        chk("arst_data", Rd_wr_data, 32'h0);
        chk("arst_err", {31'b0, Load_err}, 32'h0);
        @(posedge Clk);
        #1;
        Reset_n     = 1'b1;
        Dmem_rvalid = 1'b1;
        Dmem_rdata  = 32'hABCD_1234;
        @(posedge Clk);
        #1;
        Dmem_rvalid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("post_rst_stall", {31'b0, Wb_stall}, 32'h0);
        chk("queue_empty", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
